// File: rtl/rst_manager_if.sv
// Reset manager request/status bundle.
// The reset manager itself uses the slave modport.
// Whoever raises requests and watches the domain resets uses the master modport.
interface rst_manager_if #(
  parameter int N_DOM = 2
);
  logic             ext_rst;     // asynchronous external request, active high
  logic             sw_rst_req;  // synchronous software request pulse
  logic [N_DOM-1:0] rst_out;     // per-domain resets, active high
  logic             rst_done;    // all domains released
  logic [1:0]       rst_cause;   // 00 POR, 01 ext, 10 sw

  modport master (
    output ext_rst, sw_rst_req,
    input  rst_out, rst_done, rst_cause
  );

  modport slave (
    input  ext_rst, sw_rst_req,
    output rst_out, rst_done, rst_cause
  );
endinterface

// File: rtl/rst_manager.sv
// Reset manager.
// After every reset source releases, all domains stay in reset for a stretch period.
// The domains are then released one by one, with STAGGER cycles between releases.
// Bit 0 is released first.
module rst_manager #(
  parameter int N_DOM   = 2,
  parameter int CNT_W   = 16,
  parameter int STRETCH = 16'hFFFF,
  parameter int STAGGER = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rst_manager_if.slave  bus
);

  // The index runs 0..N_DOM, so it needs room for N_DOM itself.
  localparam int IDX_W = $clog2(N_DOM + 1);
  localparam logic [CNT_W-1:0] STRETCH_C  = CNT_W'(STRETCH);
  localparam logic [CNT_W-1:0] STAGGER_M1 = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DOM - 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REL  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] scnt_reg, scnt_next;
  logic [CNT_W-1:0] gcnt_reg, gcnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [N_DOM-1:0] rst_out_reg, rst_out_next;
  logic             done_reg, done_next;
  logic [1:0]       cause_reg, cause_next;
  logic             ext_meta_reg, ext_s_reg;
  logic [N_DOM-1:0] idx_onehot;
  logic             req_any;

  // Any accepted request source. The FSM only ever sees the synchronised ext_rst.
  assign req_any = ext_s_reg | bus.sw_rst_req;

  // Decode the domain index into a one-hot clear mask.
  genvar gi;
  generate
    for (gi = 0; gi < N_DOM; gi++) begin : g_onehot
      assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Two-flop synchroniser for the asynchronous external reset button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_meta_reg <= 1'b0;
      ext_s_reg    <= 1'b0;
    end else begin
      ext_meta_reg <= bus.ext_rst;
      ext_s_reg    <= ext_meta_reg;
    end
  end

  // State and datapath registers.
  // rst_n asserts every domain reset immediately, without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= HOLD;
      scnt_reg    <= STRETCH_C;
      gcnt_reg    <= '0;
      idx_reg     <= '0;
      rst_out_reg <= '1;
      done_reg    <= 1'b0;
      cause_reg   <= 2'b00;
    end else begin
      state_reg   <= state_next;
      scnt_reg    <= scnt_next;
      gcnt_reg    <= gcnt_next;
      idx_reg     <= idx_next;
      rst_out_reg <= rst_out_next;
      done_reg    <= done_next;
      cause_reg   <= cause_next;
    end
  end

  // Next-state logic: stretch in HOLD, stagger through REL, idle in RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HOLD: begin
        if (!req_any && scnt_reg == '0) begin
          state_next = (N_DOM > 1) ? REL : RUN;
        end
      end
      REL: begin
        if (req_any) begin
          state_next = HOLD;
        end else if (gcnt_reg == '0 && idx_reg == LAST_IDX) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (req_any) begin
          state_next = HOLD;
        end
      end
      default: state_next = HOLD;
    endcase
  end

  // Counter, domain-mask, done and cause updates that go with each state.
  always_comb begin
    scnt_next    = scnt_reg;
    gcnt_next    = gcnt_reg;
    idx_next     = idx_reg;
    rst_out_next = rst_out_reg;
    done_next    = done_reg;
    cause_next   = cause_reg;

    // ext wins when both sources request on the same cycle.
    if (ext_s_reg) begin
      cause_next = 2'b01;
    end else if (bus.sw_rst_req) begin
      cause_next = 2'b10;
    end

    case (state_reg)
      HOLD: begin
        rst_out_next = '1;
        done_next    = 1'b0;
        if (req_any) begin
          scnt_next = STRETCH_C;
        end else if (scnt_reg == '0) begin
          rst_out_next[0] = 1'b0;
          gcnt_next       = STAGGER_M1;
          idx_next        = IDX_W'(1);
          done_next       = (N_DOM == 1);
        end else begin
          scnt_next = scnt_reg - CNT_W'(1);
        end
      end
      REL: begin
        if (req_any) begin
          rst_out_next = '1;
          done_next    = 1'b0;
          scnt_next    = STRETCH_C;
        end else if (gcnt_reg == '0) begin
          // Only ever clears bits, so released domains cannot glitch high here.
          rst_out_next = rst_out_reg & ~idx_onehot;
          gcnt_next    = STAGGER_M1;
          idx_next     = idx_reg + IDX_W'(1);
          done_next    = (idx_reg == LAST_IDX);
        end else begin
          gcnt_next = gcnt_reg - CNT_W'(1);
        end
      end
      RUN: begin
        if (req_any) begin
          rst_out_next = '1;
          done_next    = 1'b0;
          scnt_next    = STRETCH_C;
        end
      end
      default: begin
        rst_out_next = '1;
        done_next    = 1'b0;
        scnt_next    = STRETCH_C;
      end
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.rst_out   = rst_out_reg;
    bus.rst_done  = done_reg;
    bus.rst_cause = cause_reg;
  end

endmodule

// File: doc/rst_manager.md
RST_MANAGER -- requirements
Module: rst_manager

Interface
REQ-001 Parameter N_DOM, default 2, number of reset domains (legal range 1 to 16).
REQ-002 Parameter CNT_W, default 16, width of the stretch and stagger counters.
REQ-003 Parameter STRETCH, default 16'hFFFF, hold cycles after any reset source releases (0 to 2^CNT_W-1).
REQ-004 Parameter STAGGER, default 16, cycles between successive domain releases (1 to 2^CNT_W-1; 0 illegal).
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low block reset (power-on).
REQ-007 ext_rst  input  1  asynchronous, active-high external reset request (button), level-sensitive.
REQ-008 sw_rst_req  input  1  synchronous, active-high software reset request, one-cycle pulse.
REQ-009 rst_out  output  N_DOM  active-high per-domain resets; bit 0 releases first.
REQ-010 rst_done  output  1  high when all domains are released.
REQ-011 rst_cause  output  2  last reset source: 00 POR, 01 ext, 10 sw, 11 reserved (never driven).

Function
REQ-012 ext_rst SHALL pass a 2-flop synchroniser (ext_s); the FSM SHALL use only ext_s.
REQ-013 The FSM SHALL have three states: HOLD, REL and RUN.
REQ-014 In HOLD: stretch counter scnt decrements by 1 per cycle; all rst_out bits are held at 1; rst_done = 0.
REQ-015 In HOLD with ext_s = 1 or sw_rst_req = 1: scnt reloads STRETCH and does not decrement that cycle.
REQ-016 In HOLD with scnt = 0 and no request: the same edge clears rst_out[0], loads the stagger counter gcnt = STAGGER-1 and sets the domain index to 1.
REQ-017 After the REQ-016 edge, the FSM SHALL go to REL when N_DOM > 1, otherwise to RUN with rst_done = 1.
REQ-018 In REL: gcnt decrements by 1 per cycle.
REQ-019 In REL with gcnt = 0: clear rst_out[index], reload gcnt = STAGGER-1, increment index.
REQ-020 When the last domain is cleared, the FSM SHALL enter RUN, and rst_done SHALL rise on that same edge.
REQ-021 Release timing: domain k deasserts on rising edge STRETCH+1+k*STAGGER, counted from the first edge after the reset source releases.
REQ-022 In REL or RUN, ext_s = 1 or sw_rst_req = 1 SHALL, on the next edge, set all rst_out to 1, clear rst_done, reload scnt = STRETCH and enter HOLD.
REQ-023 rst_cause SHALL update on the edge a request is accepted, in any state: 01 for ext, 10 for sw.
REQ-024 If ext_s and sw_rst_req are both high, ext SHALL win and rst_cause = 01.
REQ-025 rst_cause SHALL hold its value until the next accepted request or rst_n.
REQ-026 A sw_rst_req held high for several cycles SHALL behave as repeated requests, keeping scnt reloaded.
REQ-027 With STRETCH = 0, HOLD SHALL last exactly one cycle after the sources release.
REQ-028 Once cleared, rst_out bits SHALL change only to 1 (on a request or rst_n); they SHALL never glitch.
REQ-029 All rst_out bits SHALL be register outputs.

Reset
REQ-030 While rst_n = 0, asynchronously: rst_out = all 1s, rst_done = 0, rst_cause = 00, state = HOLD, scnt = STRETCH, gcnt = 0, index = 0, synchroniser flops = 0.
REQ-031 rst_out assertion SHALL be asynchronous; all releases SHALL be synchronous to clk.

Verification (N_DOM=3, STRETCH=4, STAGGER=3 unless noted)
REQ-032 POR: rst_n low for 3 cycles, then high before edge 1 -> rst_out goes 111 -> 110 at edge 5 -> 100 at edge 8 -> 000 and rst_done = 1 at edge 11; rst_cause = 00.
REQ-033 Software reset: in RUN, a one-cycle sw_rst_req pulse sampled at edge n -> after edge n, rst_out = 111, rst_done = 0, rst_cause = 10; the release sequence repeats at edges n+5, n+8 and n+11.
REQ-034 External reset: ext_rst rises before edge 1 in RUN -> rst_out = 111 at edge 3, rst_cause = 01; ext_rst held for 10 cycles keeps rst_out = 111; after ext_s falls, rst_out[0] clears exactly 5 edges later.
REQ-035 Simultaneous requests: sw_rst_req and ext_s both high in REL -> rst_out = 111, rst_cause = 01, state = HOLD.
REQ-036 Asynchronous mid-sequence reset: rst_n pulsed low between edges 6 and 7 -> rst_out = 111 immediately without waiting for a clock edge; rst_cause = 00; a full POR sequence follows.
REQ-037 Single-domain corner: N_DOM=1, STRETCH=0 -> rst_out[0] clears and rst_done rises at edge 1 after rst_n rises.
